// File: rtl/add_float.sv
`default_nettype none
// ============================================================================
// Module   : add_float
// Purpose  : Bit-serial IEEE-754 single-precision adder. Operands A then B
//            are shifted in MSB-first on one serial pin after a falling edge
//            of go. They are added by an internal parallel datapath with
//            truncation rounding, and the sum C is shifted out MSB-first.
// Ports    : clk   - rising-edge clock
//            reset - asynchronous active-low reset
//            go    - start request (high-to-low transition sampled in IDLE)
//            inpab - serial operand input, A[31]..A[0] then B[31]..B[0]
//            shift - high while out_c carries a valid result bit
//            out_c - serial result bit, C[31] first
//            over  - result overflowed (held until next start)
//            under - result underflowed (held until next start)
//            done  - one-cycle pulse after the last result bit
// Revision : 1.0 - initial release
// ============================================================================
module add_float #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic inpab,
  output logic shift,
  output logic out_c,
  output logic over,
  output logic under,
  output logic done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ALIGN  = 3'd3,
    S_ADD    = 3'd4,
    S_NORM   = 3'd5,
    S_OUT    = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_go_q;
  logic [4:0]         r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_c;
  logic               r_over;
  logic               r_under;

  // Aligned operand registers (X is the larger magnitude)
  logic               r_sx;
  logic [7:0]         r_ex;
  logic [23:0]        r_mx;
  logic [23:0]        r_my;
  logic               r_sub;
  logic               r_inf;
  logic [24:0]        r_sum;

  logic               w_start;

  // ---------------------------------------------------------------- align
  logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf;
  logic [30:0]        w_a_mag, w_b_mag;
  logic [23:0]        w_a_sig, w_b_sig, w_y_sig, w_y_al;
  logic               w_swap;
  logic [7:0]         w_ex, w_ey, w_diff;

  assign w_a_zero = (r_a[30:23] == 8'h00);
  assign w_b_zero = (r_b[30:23] == 8'h00);
  assign w_a_inf  = (r_a[30:23] == 8'hFF);
  assign w_b_inf  = (r_b[30:23] == 8'hFF);
  // Zero-exponent operands compare and add as exact zero (no denormals).
  assign w_a_mag  = w_a_zero ? 31'd0 : r_a[30:0];
  assign w_b_mag  = w_b_zero ? 31'd0 : r_b[30:0];
  assign w_a_sig  = w_a_zero ? 24'd0 : {1'b1, r_a[22:0]};
  assign w_b_sig  = w_b_zero ? 24'd0 : {1'b1, r_b[22:0]};
  assign w_swap   = (w_b_mag > w_a_mag);
  assign w_ex     = w_swap ? r_b[30:23] : r_a[30:23];
  assign w_ey     = w_swap ? r_a[30:23] : r_b[30:23];
  assign w_y_sig  = w_swap ? w_a_sig : w_b_sig;
  assign w_diff   = w_ex - w_ey;
  assign w_y_al   = (w_diff >= 8'd25) ? 24'd0 : (w_y_sig >> w_diff);

  // ------------------------------------------------------------ normalise
  logic [4:0]         w_lzc;
  logic               w_found;
  logic [22:0]        w_frac;
  logic signed [9:0]  w_exp_n;
  logic [WIDTH-1:0]   w_c;
  logic               w_over, w_under;

  always_comb begin
    w_lzc   = 5'd0;
    w_found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!w_found && r_sum[i]) begin
        w_lzc   = 5'(23 - i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_frac  = 23'd0;
    w_exp_n = 10'sd0;
    w_c     = '0;
    w_over  = 1'b0;
    w_under = 1'b0;
    if (r_sum[24]) begin
      w_frac  = r_sum[23:1];
      w_exp_n = $signed({2'b00, r_ex}) + 10'sd1;
    end else begin
      // Leading one lands at bit 23 and is dropped (hidden bit).
      w_frac  = r_sum[22:0] << w_lzc;
      w_exp_n = $signed({2'b00, r_ex}) - $signed({5'b00000, w_lzc});
    end
    if (r_inf) begin
      w_c    = {r_sx, 8'hFF, 23'd0};
      w_over = 1'b1;
    end else if (r_sum == 25'd0) begin
      w_c     = '0;
      w_under = 1'b1;
    end else if (w_exp_n <= 10'sd0) begin
      w_c     = {r_sx, 31'd0};
      w_under = 1'b1;
    end else if (w_exp_n >= 10'sd255) begin
      w_c    = {r_sx, 8'hFF, 23'd0};
      w_over = 1'b1;
    end else begin
      w_c = {r_sx, w_exp_n[7:0], w_frac};
    end
  end

  // ------------------------------------------------------------------ FSM
  assign w_start = (go == 1'b0) && r_go_q;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_LOAD_A;
      S_LOAD_A: if (r_cnt == 5'd31) w_next = S_LOAD_B;
      S_LOAD_B: if (r_cnt == 5'd31) w_next = S_ALIGN;
      S_ALIGN:  w_next = S_ADD;
      S_ADD:    w_next = S_NORM;
      S_NORM:   w_next = S_OUT;
      S_OUT:    if (r_cnt == 5'd31) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_go_q  <= 1'b0;
      r_cnt   <= 5'd0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_over  <= 1'b0;
      r_under <= 1'b0;
      r_sx    <= 1'b0;
      r_ex    <= 8'd0;
      r_mx    <= 24'd0;
      r_my    <= 24'd0;
      r_sub   <= 1'b0;
      r_inf   <= 1'b0;
      r_sum   <= 25'd0;
    end else begin
      r_go_q  <= go;
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_over  <= 1'b0;
            r_under <= 1'b0;
            r_cnt   <= 5'd0;
          end
        end
        S_LOAD_A: begin
          r_a   <= {r_a[WIDTH-2:0], inpab};
          r_cnt <= r_cnt + 5'd1;
        end
        S_LOAD_B: begin
          r_b   <= {r_b[WIDTH-2:0], inpab};
          r_cnt <= r_cnt + 5'd1;
        end
        S_ALIGN: begin
          r_inf <= w_a_inf | w_b_inf;
          // An infinite operand dictates the result sign (A wins a tie).
          if (w_a_inf)      r_sx <= r_a[31];
          else if (w_b_inf) r_sx <= r_b[31];
          else              r_sx <= w_swap ? r_b[31] : r_a[31];
          r_ex  <= w_ex;
          r_mx  <= w_swap ? w_b_sig : w_a_sig;
          r_my  <= w_y_al;
          r_sub <= r_a[31] ^ r_b[31];
        end
        S_ADD: begin
          r_sum <= r_sub ? ({1'b0, r_mx} - {1'b0, r_my})
                         : ({1'b0, r_mx} + {1'b0, r_my});
        end
        S_NORM: begin
          r_c     <= w_c;
          r_over  <= w_over;
          r_under <= w_under;
        end
        S_OUT: begin
          r_c   <= {r_c[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign shift = (r_state == S_OUT);
  assign out_c = shift & r_c[WIDTH-1];
  assign done  = (r_state == S_DONE);
  assign over  = r_over;
  assign under = r_under;

endmodule
`default_nettype wire

// File: tb/tb_add_float.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_float
// Purpose  : Directed self-checking bench for the bit-serial FP32 adder.
//            Each vector is shifted in, and the serial result, output
//            timing, and flags are compared to hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_float;

  logic clk;
  logic reset;
  logic go;
  logic inpab;
  logic shift;
  logic out_c;
  logic over;
  logic under;
  logic done;

  int n_checks;
  int n_pass;

  add_float #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .inpab (inpab),
    .shift (shift),
    .out_c (out_c),
    .over  (over),
    .under (under),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Run one add: go pulse, 64 serial bits, then cycle-exact output checks.
  task automatic run_op(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_c,
                        input logic exp_over, input logic exp_under);
    logic [63:0] ab;
    logic [31:0] c_got;
    int          pre_bad;
    int          sh_bad;
    ab = {a, b};
    @(negedge clk) go = 1'b1;
    @(negedge clk);
    @(negedge clk) go = 1'b0;           // start edge follows
    for (int i = 63; i >= 0; i--) begin
      @(negedge clk) inpab = ab[i];
    end
    pre_bad = 0;
    for (int j = 0; j < 3; j++) begin   // ALIGN, ADD, NORM
      @(negedge clk);
      if (shift !== 1'b0 || done !== 1'b0) pre_bad++;
    end
    check_val({tag, " quiet_before_out"}, 32'(pre_bad), 32'd0);
    c_got  = '0;
    sh_bad = 0;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      if (shift !== 1'b1 || done !== 1'b0) sh_bad++;
      c_got = {c_got[30:0], out_c};
    end
    check_val({tag, " shift_window"}, 32'(sh_bad), 32'd0);
    check_val({tag, " C"}, c_got, exp_c);
    @(negedge clk);
    check_val({tag, " done_pulse"}, {30'd0, shift, done}, 32'd1);
    check_val({tag, " over"}, {31'd0, over}, {31'd0, exp_over});
    check_val({tag, " under"}, {31'd0, under}, {31'd0, exp_under});
    @(negedge clk);
    check_val({tag, " done_end"}, {30'd0, shift, done}, 32'd0);
  endtask

  initial begin
    int bad;
    logic [63:0] ab;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    go       = 1'b1;
    inpab    = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", {27'd0, shift, out_c, over, under, done}, 32'd0);
    reset = 1'b1;

    run_op("cancel",   32'h3F600000, 32'hBF600000, 32'h00000000, 1'b0, 1'b1);
    run_op("one_one",  32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    run_op("sub_half", 32'h3FC00000, 32'hBF000000, 32'h3F800000, 1'b0, 1'b0);
    run_op("lshift2",  32'h3F800000, 32'hBF400000, 32'h3E800000, 1'b0, 1'b0);
    run_op("ovf_max",  32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0);
    run_op("trunc",    32'h3F800000, 32'h30800000, 32'h3F800000, 1'b0, 1'b0);
    run_op("inf_in",   32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b1, 1'b0);
    run_op("unf_exp",  32'h00800000, 32'h80C00000, 32'h80000000, 1'b0, 1'b1);
    run_op("zero_in",  32'h00000000, 32'h40400000, 32'h40400000, 1'b0, 1'b0);

    // Abort during LOAD_B with reset; go stays low across reset.
    ab = {32'h3F800000, 32'h3F800000};
    @(negedge clk) go = 1'b1;
    @(negedge clk);
    @(negedge clk) go = 1'b0;
    for (int i = 63; i >= 24; i--) begin
      @(negedge clk) inpab = ab[i];
    end
    #2 reset = 1'b0;
    #1 check_val("abort_outputs", {27'd0, shift, out_c, over, under, done}, 32'd0);
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    bad = 0;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk) inpab = ~inpab;
      if (shift !== 1'b0 || done !== 1'b0) bad++;
    end
    check_val("no_start_after_reset", 32'(bad), 32'd0);
    inpab = 1'b0;
    run_op("restart",  32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
